// File: rtl/fibonacci_pkg.sv
// Shared types and default widths for the Fibonacci stream generator.
package fibonacci_pkg;

    localparam int FIB_DATA_W = 16;
    localparam int FIB_TERM_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        OUT    = 2'd2,
        STREAM = 2'd3
    } t_fib_state;

    typedef enum logic {
        FIB_SINGLE = 1'b0,
        FIB_STREAM = 1'b1
    } t_fib_mode;

endpackage

// File: rtl/fibonacci_step.sv
// One Fibonacci recurrence step with per-value overflow flags.
// Define FIBONACCI_SAT_EN to saturate overflowed values to all ones.
module fibonacci_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_ovf,
    input  logic              b_ovf,
    output logic [DATA_W-1:0] next_a,
    output logic [DATA_W-1:0] next_b,
    output logic              next_a_ovf,
    output logic              next_b_ovf
);

    logic [DATA_W:0] sum;

    assign sum        = {1'b0, a} + {1'b0, b};
    assign next_a     = b;
    assign next_a_ovf = b_ovf;
    // Sticky: once either operand has overflowed, every later value has too.
    assign next_b_ovf = a_ovf | b_ovf | sum[DATA_W];

`ifdef FIBONACCI_SAT_EN
    assign next_b = next_b_ovf ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    assign next_b = sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/fibonacci_stream.sv
// Fibonacci generator: single-value or streamed F(0)..F(n) over valid/ready.
// Optional saturation of overflowed values via macro FIBONACCI_SAT_EN.
//
// Output handshake: a beat transfers on any rising edge where out_valid and
// out_ready are both high; once out_valid rises it stays high, with
// out_result/out_last/out_overflow held stable, until that transfer happens.
module fibonacci_stream
    import fibonacci_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W,
    parameter int TERM_W = FIB_TERM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TERM_W-1:0] term,
    input  logic              mode,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_last,
    output logic              out_overflow,
    output t_fib_state        fsm_state
);

    t_fib_state        state;
    t_fib_state        next_state;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              a_ovf;
    logic              b_ovf;
    logic [TERM_W-1:0] cnt;
    logic [TERM_W-1:0] term_q;
    logic              load;
    logic              advance;
    logic              at_last;

    logic [DATA_W-1:0] step_a;
    logic [DATA_W-1:0] step_b;
    logic              step_a_ovf;
    logic              step_b_ovf;

    fibonacci_step #(.DATA_W(DATA_W)) u_step (
        .a          (a),
        .b          (b),
        .a_ovf      (a_ovf),
        .b_ovf      (b_ovf),
        .next_a     (step_a),
        .next_b     (step_b),
        .next_a_ovf (step_a_ovf),
        .next_b_ovf (step_b_ovf)
    );

    assign at_last   = (cnt == term_q);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (t_fib_mode'(mode) == FIB_STREAM) ? STREAM : CALC;
                end
            end
            CALC: begin
                if (at_last) next_state = OUT;
                else         advance    = 1'b1;
            end
            OUT: begin
                if (out_ready) next_state = IDLE;
            end
            STREAM: begin
                // Advancing on the transfer edge presents the next beat on the following cycle.
                if (out_ready) begin
                    if (at_last) next_state = IDLE;
                    else         advance    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            cnt    <= '0;
            term_q <= '0;
        end else if (load) begin
            a      <= '0;
            b      <= {{(DATA_W-1){1'b0}}, 1'b1};
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            cnt    <= '0;
            term_q <= term;
        end else if (advance) begin
            a      <= step_a;
            b      <= step_b;
            a_ovf  <= step_a_ovf;
            b_ovf  <= step_b_ovf;
            cnt    <= cnt + TERM_W'(1);
        end
    end

    assign busy         = (state != IDLE);
    assign out_valid    = (state == OUT) || (state == STREAM);
    assign out_last     = (state == OUT) || ((state == STREAM) && at_last);
    assign out_result   = out_valid ? a : '0;
    assign out_overflow = out_valid & a_ovf;

endmodule

// File: tb/tb_fibonacci_stream.sv
// Self-checking bench for fibonacci_stream against an arithmetic Fibonacci model.
// Honours FIBONACCI_SAT_EN the same way as the design build.
module tb_fibonacci_stream;
    import fibonacci_pkg::*;

    localparam int DATA_W = 16;
    localparam int TERM_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [TERM_W-1:0] term = '0;
    logic              mode = 1'b0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic              out_last;
    logic              out_overflow;
    t_fib_state        fsm_state;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;
    int cycle = 0;
    int start_cycle = 0;
    logic [DATA_W+1:0] exp_q[$];

    fibonacci_stream #(.DATA_W(DATA_W), .TERM_W(TERM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .term         (term),
        .mode         (mode),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_last     (out_last),
        .out_overflow (out_overflow),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint fib(input int k);
        longint x = 0;
        longint y = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [DATA_W+1:0] model_beat(input int k, input bit last);
        longint            f;
        logic              ovf;
        logic [DATA_W-1:0] v;
        f   = fib(k);
        ovf = (f >= (longint'(1) << DATA_W));
        v   = f[DATA_W-1:0];
`ifdef FIBONACCI_SAT_EN
        if (ovf) v = '1;
`endif
        return {last, ovf, v};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_expected(input int t, input bit m);
        if (m) begin
            for (int k = 0; k <= t; k++) exp_q.push_back(model_beat(k, k == t));
        end else begin
            exp_q.push_back(model_beat(t, 1'b1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_start(input int t, input bit m);
        @(posedge clk);
        #1;
        start = 1'b1;
        term  = t[TERM_W-1:0];
        mode  = m;
        @(posedge clk);
        #1;
        start_cycle = cycle;
        start = 1'b0;
        term  = TERM_W'($urandom);
        mode  = 1'($urandom);
    endtask

    // rdy: 0 always ready, 1 toggling, 2 random.
    // inject: 1 start pulse while busy, 2 start coinciding with the last transfer.
    task automatic collect(input int t, input bit m, input int rdy, input int inject);
        int                iter = 0;
        bit                done = 0;
        bit                first = 1;
        bit                stalled = 0;
        logic [DATA_W+1:0] held = '0;
        logic [DATA_W+1:0] e;
        int                first_cyc = 0;
        int                last_cyc = 0;
        while (!done && iter < 400) begin
            case (rdy)
                0:       out_ready = 1'b1;
                1:       out_ready = (iter % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject == 1 && iter == 2) begin
                start = 1'b1;
                term  = TERM_W'(2);
                mode  = 1'b0;
            end else if (inject == 1 && iter == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                if (first) begin
                    first = 0;
                    first_cyc = cycle;
                    check("first_valid_latency", cycle - start_cycle, m ? 0 : t + 1);
                end
                if (stalled) check("stall_stable", {out_last, out_overflow, out_result}, held);
                if (out_ready) begin
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", exp_q.size(), 1);
                        done = 1;
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_value", out_result, e[DATA_W-1:0]);
                        check("beat_overflow", out_overflow, e[DATA_W]);
                        check("beat_last", out_last, e[DATA_W+1]);
                        if (out_last) begin
                            done = 1;
                            last_cyc = cycle;
                            if (inject == 2) begin
                                start = 1'b1;
                                term  = TERM_W'(5);
                                mode  = 1'b1;
                            end
                        end
                    end
                end else begin
                    stalled = 1;
                    held = {out_last, out_overflow, out_result};
                end
            end else if (stalled) begin
                check("valid_dropped_in_stall", out_valid, 1);
                stalled = 0;
            end
            @(posedge clk);
            #1;
            start = (inject == 1 && iter == 2) ? start : 1'b0;
            iter++;
        end
        start = 1'b0;
        check("request_completed", done, 1);
        if (done && rdy == 0 && m) check("stream_gapless", last_cyc - first_cyc, t);
        check("busy_after_last", busy, 0);
        check("valid_after_last", out_valid, 0);
        check("expected_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        if (inject != 0) begin
            repeat (3) begin
                @(negedge clk);
                check("no_spurious_request", out_valid | busy, 0);
            end
        end
    endtask

    task automatic run_request(input int t, input bit m, input int rdy, input int inject);
        push_expected(t, m);
        drive_start(t, m);
        collect(t, m, rdy, inject);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_result"}, out_result, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_overflow"}, out_overflow, 0);
        check({tag, "_state"}, fsm_state, IDLE);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int                n;
        int                iter;
        logic [DATA_W+1:0] e;

        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_request(7, 1'b0, 0, 0);
        run_request(5, 1'b1, 0, 0);
        run_request(10, 1'b1, 1, 0);
        run_request(25, 1'b0, 0, 0);
        run_request(24, 1'b0, 1, 0);
        run_request(0, 1'b0, 0, 0);
        run_request(0, 1'b1, 2, 0);
        run_request(9, 1'b0, 0, 1);
        run_request(4, 1'b1, 0, 2);
        run_request(6, 1'b0, 2, 2);
        run_request(31, 1'b1, 2, 0);

        // Asynchronous reset in the middle of a stream.
        drive_start(20, 1'b1);
        out_ready = 1'b1;
        n = 0;
        iter = 0;
        while (n < 5 && iter < 50) begin
            @(negedge clk);
            if (out_valid) begin
                e = model_beat(n, 1'b0);
                check("pre_reset_beat", out_result, e[DATA_W-1:0]);
                n++;
            end
            iter++;
        end
        check("pre_reset_beats_seen", n, 5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_stream_reset");
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        start = 1'b1;
        term  = TERM_W'(3);
        mode  = 1'b0;
        @(posedge clk);
        #1;
        start_cycle = cycle;
        start = 1'b0;
        push_expected(3, 1'b0);
        collect(3, 1'b0, 0, 0);

        repeat (20) begin
            run_request($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fibonacci_stream.md
FIBONACCI_STREAM -- requirements
Module: fibonacci_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of result datapath (min 8).
REQ-002 SHALL have parameter TERM_W, default 5, width of requested term index.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request new sequence; sampled only in IDLE.
REQ-006 SHALL have port term  input  TERM_W  last Fibonacci index n; captured with start.
REQ-007 SHALL have port mode  input  1  0 = single (emit F(n) only), 1 = stream (emit F(0)..F(n)); captured with start.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port out_valid  output  1  out_result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts; transfer = out_valid && out_ready.
REQ-011 SHALL have port out_result  output  DATA_W  Fibonacci value.
REQ-012 SHALL have port out_last  output  1  final beat of the request.
REQ-013 SHALL have port out_overflow  output  1  true F(index) >= 2^DATA_W for the presented beat.

Function
REQ-014 SHALL use F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
REQ-015 SHALL implement FSM IDLE, CALC, OUT, STREAM.
REQ-016 IDLE: start=1 -> capture term/mode, a=0, b=1, cnt=0; go CALC if mode=0, STREAM if mode=1.
REQ-017 CALC: cnt<term -> a<=b, b<=a+b, cnt++; cnt==term -> OUT; out_valid first high term+1 cycles after start edge.
REQ-018 OUT: out_valid=1, out_result=a, out_last=1; hold all outputs stable until transfer, then IDLE.
REQ-019 STREAM: out_valid=1, out_result=a, out_last=(cnt==term); on transfer: out_last -> IDLE, else advance as REQ-017 and stay.
REQ-020 Stream beats SHALL be back-to-back (one per cycle) while out_ready=1; no gap cycles.
REQ-021 out_valid SHALL never drop without a transfer; outputs stable while stalled.
REQ-022 start while busy SHALL be ignored; term/mode changes while busy SHALL have no effect.
REQ-023 Overflow flag SHALL be tracked per value (carry of a+b sticky into b's flag, shifted into a's flag), so out_overflow is exact for each beat and remains set for all higher indices.
REQ-024 Without saturation, out_result SHALL be F(index) mod 2^DATA_W.
REQ-025 term=0 SHALL yield one beat F(0)=0, out_last=1, in both modes.
REQ-026 Transfer in OUT/STREAM-last with start=1 same cycle: start SHALL be ignored (sampled only in IDLE).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, busy=0, out_valid=0, out_result=0, out_last=0, out_overflow=0, internal a/b/cnt/flags=0, at any time incl. mid-sequence.
REQ-028 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro FIBONACCI_SAT_EN SHALL select saturation.
REQ-030 With FIBONACCI_SAT_EN defined: any value whose overflow flag is set SHALL present out_result = all ones (65535 at DATA_W=16).
REQ-031 Without it: wrap modulo 2^DATA_W per REQ-024; out_overflow identical in both builds.

Structure
REQ-032 fibonacci_pkg SHALL hold t_fib_state enum (IDLE, CALC, OUT, STREAM), t_fib_mode enum (FIB_SINGLE=0, FIB_STREAM=1), default constants FIB_DATA_W=16, FIB_TERM_W=5.
REQ-033 Sub-module fibonacci_step SHALL implement one recurrence step: inputs a, b, a/b overflow flags; outputs next a, next b, next flags, with saturation per macro.
REQ-034 Top SHALL contain FSM, capture registers, handshake logic only.

Verification
REQ-035 Single, term=7, out_ready=1 -> one beat 13, out_last=1, out_overflow=0, valid 8 cycles after start.
REQ-036 Stream, term=5, out_ready=1 -> beats 0,1,1,2,3,5 on consecutive cycles, out_last only on 5, then busy=0.
REQ-037 Stream, term=10, out_ready toggling 1/0 each cycle -> sequence 0..55 intact, no duplicates or drops, outputs stable in stall cycles.
REQ-038 Single, term=25, DATA_W=16 -> out_overflow=1, out_result 9489 (no macro) or 65535 (FIBONACCI_SAT_EN); term=24 -> 46368, out_overflow=0.
REQ-039 rst_n pulsed low mid-stream (term=20, after beat 4) -> outputs zero immediately; new start term=3 single -> 2.
REQ-040 start pulsed with term=2 while busy on term=9 single -> only 34 emitted, second request ignored.
